// File: rtl/gray_pkg.sv
// Shared types and Gray/binary conversion helpers for the Gray step sequencer.
package gray_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    localparam int unsigned DefWidth = 4;
    localparam int unsigned DefCntW  = 8;

    // Helpers work on zero-extended values, so they serve any width up to 32.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_step_core.sv
// Gray-code register: advances one Gray step up or down whenever en is high.
module gray_step_core
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] bin_nxt;
    logic [WIDTH-1:0] q_nxt;

    // Step in the binary domain so wrap-around is plain modular arithmetic.
    always_comb begin
        bin     = WIDTH'(gray2bin(32'(q)));
        bin_nxt = dir ? bin + WIDTH'(1) : bin - WIDTH'(1);
        q_nxt   = WIDTH'(bin2gray(32'(bin_nxt)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= q_nxt;
        end
    end

    assign qbar = ~q;

endmodule

// File: rtl/gray_step_ctrl.sv
// Commanded Gray counter sequencer: runs N steps up/down with pause, then pulses done.
// Define GRAY_STEP_CHK_EN to build the sticky single-bit-change checker behind err.
module gray_step_ctrl
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] steps,
    input  logic             pause,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             err
);

    state_t           state;
    logic [CNT_W-1:0] rem;
    logic             dir_l;
    logic             en;

    assign en = (state == StRun) && !pause;

    gray_step_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .dir (dir_l),
        .q   (q),
        .qbar(qbar)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StIdle;
            rem   <= '0;
            dir_l <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        if (steps != '0) begin
                            rem   <= steps;
                            dir_l <= dir;
                            busy  <= 1'b1;
                            state <= StRun;
                        end else begin
                            done  <= 1'b1;
                            state <= StDone;
                        end
                    end
                end
                StRun: begin
                    if (!pause) begin
                        rem <= rem - CNT_W'(1);
                        if (rem == CNT_W'(1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= StDone;
                        end
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef GRAY_STEP_CHK_EN
    logic [WIDTH-1:0] q_prev;
    logic [WIDTH-1:0] diff;
    logic             chk_valid;

    assign diff = q ^ q_prev;

    // chk_valid keeps the edge out of reset from being compared.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_prev    <= '0;
            chk_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            q_prev    <= q;
            chk_valid <= 1'b1;
            if (chk_valid && ((diff & (diff - WIDTH'(1))) != '0)) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_step_ctrl.sv
// Self-checking bench for gray_step_ctrl: vector table, directed corner cases, random vs model.
module tb_gray_step_ctrl;

    localparam int W  = 4;
    localparam int CW = 8;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          dir   = 1'b0;
    logic          pause = 1'b0;
    logic [CW-1:0] steps = '0;
    logic          busy;
    logic          done;
    logic          err;
    logic [W-1:0]  q;
    logic [W-1:0]  qbar;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: position along the Gray sequence plus outstanding work.
    int gtab[16];
    int m_pos  = 0;
    int m_rem  = 0;
    int m_d    = 1;
    bit m_done = 1'b0;

    gray_step_ctrl #(
        .WIDTH(W),
        .CNT_W(CW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .dir  (dir),
        .steps(steps),
        .pause(pause),
        .busy (busy),
        .done (done),
        .q    (q),
        .qbar (qbar),
        .err  (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r;
        logic s;
        logic d;
        int   n;
        logic p;
        int   eq;
        int   eb;
        int   ed;
    } vec_t;

    vec_t tab[15];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_pos  = 0;
            m_rem  = 0;
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_rem > 0) begin
            if (!pause) begin
                m_pos = (m_pos + m_d + 16) % 16;
                m_rem--;
                if (m_rem == 0) m_done = 1'b1;
            end
        end else if (start) begin
            if (steps == 0) begin
                m_done = 1'b1;
            end else begin
                m_rem = int'(steps);
                m_d   = dir ? 1 : -1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("q", int'(q), gtab[m_pos]);
        check("qbar", int'(qbar), gtab[m_pos] ^ 15);
        check("busy", int'(busy), int'(m_rem > 0));
        check("done", int'(done), int'(m_done));
        check("err", int'(err), 0);
    endtask

    task automatic drive(input logic r, input logic s, input logic d, input int n, input logic p);
        rst   = r;
        start = s;
        dir   = d;
        steps = CW'(n);
        pause = p;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        for (int i = 0; i < limit; i++) begin
            tick();
            cyc++;
            if (done) return;
        end
        check("done_timeout", 0, 1);
    endtask

    int cyc;
    int seen;

    initial begin
        // Gray table by reflect-and-prefix construction.
        gtab[0] = 0;
        gtab[1] = 1;
        for (int k = 1; k < 4; k++) begin
            for (int i = 0; i < (1 << k); i++) begin
                gtab[(1 << k) + i] = gtab[(1 << k) - 1 - i] | (1 << k);
            end
        end

        // rst start dir steps pause | q busy done
        tab[0]  = '{1, 0, 0, 0, 0,  0, 0, 0};
        tab[1]  = '{1, 0, 0, 0, 0,  0, 0, 0};
        tab[2]  = '{0, 1, 1, 5, 0,  0, 1, 0};
        tab[3]  = '{0, 0, 0, 0, 0,  1, 1, 0};
        tab[4]  = '{0, 0, 0, 0, 0,  3, 1, 0};
        tab[5]  = '{0, 0, 0, 0, 0,  2, 1, 0};
        tab[6]  = '{0, 0, 0, 0, 0,  6, 1, 0};
        tab[7]  = '{0, 0, 0, 0, 0,  7, 0, 1};
        tab[8]  = '{0, 0, 0, 0, 0,  7, 0, 0};
        tab[9]  = '{1, 0, 0, 0, 0,  0, 0, 0};
        tab[10] = '{0, 1, 0, 3, 0,  0, 1, 0};
        tab[11] = '{0, 0, 0, 0, 0,  8, 1, 0};
        tab[12] = '{0, 0, 0, 0, 0,  9, 1, 0};
        tab[13] = '{0, 0, 0, 0, 0, 11, 0, 1};
        tab[14] = '{0, 0, 0, 0, 0, 11, 0, 0};

        for (int i = 0; i < 15; i++) begin
            drive(tab[i].r, tab[i].s, tab[i].d, tab[i].n, tab[i].p);
            tick();
            check("tab_q", int'(q), tab[i].eq);
            check("tab_qbar", int'(qbar), tab[i].eq ^ 15);
            check("tab_busy", int'(busy), tab[i].eb);
            check("tab_done", int'(done), tab[i].ed);
        end

        // 16 steps up returns to the starting value 1011.
        drive(0, 1, 1, 16, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) tick();
        tick();
        check("wrap16_q", int'(q), 11);
        check("wrap16_done", int'(done), 1);
        check("wrap16_err", int'(err), 0);
        tick();

        // Pause for two cycles after the second step.
        drive(1, 0, 0, 0, 0);
        tick();
        drive(0, 1, 1, 4, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        pause = 1'b1;
        tick();
        check("pause_hold1", int'(q), 3);
        tick();
        check("pause_hold2", int'(q), 3);
        pause = 1'b0;
        wait_done(10, cyc);
        check("pause_done_lat", cyc, 2);
        check("pause_final_q", int'(q), 6);
        tick();

        // Zero-step request: done only, q untouched.
        drive(0, 1, 1, 0, 0);
        tick();
        check("zero_done", int'(done), 1);
        check("zero_busy", int'(busy), 0);
        check("zero_q", int'(q), 6);
        drive(0, 0, 0, 0, 0);
        tick();
        check("zero_done_clr", int'(done), 0);

        // Start during RUN is ignored: three steps up from 0110 land on 0100.
        drive(0, 1, 1, 3, 0);
        tick();
        drive(0, 1, 0, 7, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        wait_done(10, cyc);
        check("busy_start_q", int'(q), gtab[7]);
        check("busy_start_lat", cyc, 2);
        tick();

        // Reset after the 3rd of 10 steps aborts without done.
        drive(1, 0, 0, 0, 0);
        tick();
        drive(0, 1, 1, 10, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        check("midrun_q", int'(q), 2);
        rst = 1'b1;
        tick();
        check("abort_q", int'(q), 0);
        check("abort_busy", int'(busy), 0);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) seen++;
        end
        check("abort_no_done", seen, 0);
        drive(0, 1, 1, 2, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        wait_done(10, cyc);
        check("after_abort_q", int'(q), 3);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 30), 1'($urandom),
                  int'($urandom_range(0, 20)), ($urandom_range(0, 99) < 25));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
